// File: rtl/branch_fwd_pkg.sv
// Shared types and constants for the ID-stage branch operand forwarding unit.
package branch_fwd_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_M  = 2'd1,
        FWD_W  = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int MAX_STALL = 2;

    function automatic logic [1:0] max_cost(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_fwd_sel.sv
// Per-operand forwarding select, operand mux and hazard cost for one branch source register.
module branch_fwd_sel
    import branch_fwd_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            branch_i,
    input  logic [RA_W-1:0] rs_addr_i,
    input  logic [XLEN-1:0] rs_data_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic            ex_we_i,
    input  logic            ex_ld_i,
    input  logic [RA_W-1:0] m_rd_i,
    input  logic            m_we_i,
    input  logic            m_ld_i,
    input  logic [RA_W-1:0] w_rd_i,
    input  logic            w_we_i,
    input  logic [XLEN-1:0] alu_m_i,
    input  logic [XLEN-1:0] wb_w_i,
    output logic [XLEN-1:0] operand_o,
    output fwd_sel_e        sel_o,
    output logic [1:0]      cost_o
);

    logic rs_nz;
    logic ex_hit;
    logic m_hit;
    logic w_hit;

    // x0 is hardwired zero: it never matches a producer and never costs a stall.
    assign rs_nz  = |rs_addr_i;
    assign ex_hit = rs_nz & ex_we_i & (ex_rd_i == rs_addr_i);
    assign m_hit  = rs_nz & m_we_i  & (m_rd_i  == rs_addr_i);
    assign w_hit  = rs_nz & w_we_i  & (w_rd_i  == rs_addr_i);

    always_comb begin
        sel_o     = FWD_RF;
        operand_o = rs_data_i;
        if (m_hit && !m_ld_i) begin
            sel_o     = FWD_M;
            operand_o = alu_m_i;
        end else if (w_hit) begin
            sel_o     = FWD_W;
            operand_o = wb_w_i;
        end
    end

    // The youngest producer (EX) decides the cost before an older load in M.
    always_comb begin
        cost_o = 2'd0;
        if (branch_i) begin
            if (ex_hit) begin
                cost_o = ex_ld_i ? 2'd2 : 2'd1;
            end else if (m_hit && m_ld_i) begin
                cost_o = 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_fwd_unit.sv
// ID-stage branch operand forwarding and stall control; define BRANCH_FWD_STATS_EN to add
// saturating stall-cycle and forward-event counters.
module branch_fwd_unit
    import branch_fwd_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            branch_i,
    input  logic            flush_i,
    input  logic [RA_W-1:0] rs1_addr_i,
    input  logic [RA_W-1:0] rs2_addr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic [RA_W-1:0] m_rd_i,
    input  logic [RA_W-1:0] w_rd_i,
    input  logic            ex_we_i,
    input  logic            m_we_i,
    input  logic            w_we_i,
    input  logic            ex_ld_i,
    input  logic            m_ld_i,
    input  logic [XLEN-1:0] alu_m_i,
    input  logic [XLEN-1:0] wb_w_i,
    output logic [XLEN-1:0] a_operand_o,
    output logic [XLEN-1:0] b_operand_o,
    output logic [1:0]      sel_a_o,
    output logic [1:0]      sel_b_o,
    output logic            stall_o,
    output logic            opnd_valid_o,
    output state_e          dbg_state_o
`ifdef BRANCH_FWD_STATS_EN
    ,
    output logic [31:0]     stall_cyc_o,
    output logic [31:0]     fwd_evt_o
`endif
);

    logic [XLEN-1:0] a_fwd;
    logic [XLEN-1:0] b_fwd;
    fwd_sel_e        sel_a;
    fwd_sel_e        sel_b;
    logic [1:0]      cost_a;
    logic [1:0]      cost_b;
    logic [1:0]      n_stall;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    branch_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_sel_a (
        .branch_i  (branch_i),
        .rs_addr_i (rs1_addr_i),
        .rs_data_i (rs1_data_i),
        .ex_rd_i   (ex_rd_i),
        .ex_we_i   (ex_we_i),
        .ex_ld_i   (ex_ld_i),
        .m_rd_i    (m_rd_i),
        .m_we_i    (m_we_i),
        .m_ld_i    (m_ld_i),
        .w_rd_i    (w_rd_i),
        .w_we_i    (w_we_i),
        .alu_m_i   (alu_m_i),
        .wb_w_i    (wb_w_i),
        .operand_o (a_fwd),
        .sel_o     (sel_a),
        .cost_o    (cost_a)
    );

    branch_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_sel_b (
        .branch_i  (branch_i),
        .rs_addr_i (rs2_addr_i),
        .rs_data_i (rs2_data_i),
        .ex_rd_i   (ex_rd_i),
        .ex_we_i   (ex_we_i),
        .ex_ld_i   (ex_ld_i),
        .m_rd_i    (m_rd_i),
        .m_we_i    (m_we_i),
        .m_ld_i    (m_ld_i),
        .w_rd_i    (w_rd_i),
        .w_we_i    (w_we_i),
        .alu_m_i   (alu_m_i),
        .wb_w_i    (wb_w_i),
        .operand_o (b_fwd),
        .sel_o     (sel_b),
        .cost_o    (cost_b)
    );

    assign n_stall = max_cost(cost_a, cost_b);

    // Reset forces the plain register-file path; flush leaves operands visible but never stalls.
    assign a_operand_o = rst_i ? rs1_data_i : a_fwd;
    assign b_operand_o = rst_i ? rs2_data_i : b_fwd;
    assign sel_a_o     = rst_i ? FWD_RF : sel_a;
    assign sel_b_o     = rst_i ? FWD_RF : sel_b;

    assign stall_o = !rst_i && !flush_i &&
                     ((state_q == WAIT) || (n_stall != 2'd0));

    // opnd_valid_o: one-cycle qualifier, high when ID holds a branch whose operands are final
    // (not stalled, not flushed); the consumer samples operands only in cycles where it is high.
    assign opnd_valid_o = !rst_i && branch_i && !stall_o && !flush_i;
    assign dbg_state_o  = state_q;

    // The IDLE cycle that detects the hazard is the first stall; WAIT covers the rest.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (n_stall == 2'(MAX_STALL)) begin
                        state_d = WAIT;
                        cnt_d   = 2'(MAX_STALL - 1);
                    end
                end
                WAIT: begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = IDLE;
                        cnt_d   = 2'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BRANCH_FWD_STATS_EN
    logic [31:0] stall_cyc_q;
    logic [31:0] fwd_evt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cyc_q <= 32'd0;
            fwd_evt_q   <= 32'd0;
        end else begin
            if (stall_o && (stall_cyc_q != '1)) begin
                stall_cyc_q <= stall_cyc_q + 32'd1;
            end
            if (opnd_valid_o && ((sel_a != FWD_RF) || (sel_b != FWD_RF)) &&
                (fwd_evt_q != '1)) begin
                fwd_evt_q <= fwd_evt_q + 32'd1;
            end
        end
    end

    assign stall_cyc_o = stall_cyc_q;
    assign fwd_evt_o   = fwd_evt_q;
`endif

endmodule

// File: tb/tb_branch_fwd_unit.sv
// Directed self-checking bench for branch_fwd_unit: forwarding priority, x0, stall lengths,
// flush and reset abort, plus counters when BRANCH_FWD_STATS_EN is defined.
module tb_branch_fwd_unit;
    import branch_fwd_pkg::*;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [XLEN-1:0] RS1_D = 32'h1111_0001;
    localparam logic [XLEN-1:0] RS2_D = 32'h2222_0002;
    localparam logic [XLEN-1:0] ALU_D = 32'hAAAA_5555;
    localparam logic [XLEN-1:0] WB_D  = 32'hBBBB_6666;

    logic            clk = 1'b0;
    logic            rst;
    logic            branch;
    logic            flush;
    logic [RA_W-1:0] rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [RA_W-1:0] ex_rd, m_rd, w_rd;
    logic            ex_we, m_we, w_we, ex_ld, m_ld;
    logic [XLEN-1:0] alu_m, wb_w;
    logic [XLEN-1:0] a_op, b_op;
    logic [1:0]      sel_a, sel_b;
    logic            stall, opnd_valid;
    state_e          dbg_state;
`ifdef BRANCH_FWD_STATS_EN
    logic [31:0]     stall_cyc, fwd_evt;
`endif

    int checks = 0;
    int errors = 0;

    branch_fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .branch_i     (branch),
        .flush_i      (flush),
        .rs1_addr_i   (rs1_addr),
        .rs2_addr_i   (rs2_addr),
        .rs1_data_i   (rs1_data),
        .rs2_data_i   (rs2_data),
        .ex_rd_i      (ex_rd),
        .m_rd_i       (m_rd),
        .w_rd_i       (w_rd),
        .ex_we_i      (ex_we),
        .m_we_i       (m_we),
        .w_we_i       (w_we),
        .ex_ld_i      (ex_ld),
        .m_ld_i       (m_ld),
        .alu_m_i      (alu_m),
        .wb_w_i       (wb_w),
        .a_operand_o  (a_op),
        .b_operand_o  (b_op),
        .sel_a_o      (sel_a),
        .sel_b_o      (sel_b),
        .stall_o      (stall),
        .opnd_valid_o (opnd_valid),
        .dbg_state_o  (dbg_state)
`ifdef BRANCH_FWD_STATS_EN
        ,
        .stall_cyc_o  (stall_cyc),
        .fwd_evt_o    (fwd_evt)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic clear_pipe();
        branch   = 1'b0;
        flush    = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        rs1_data = RS1_D;
        rs2_data = RS2_D;
        ex_rd    = '0;
        m_rd     = '0;
        w_rd     = '0;
        ex_we    = 1'b0;
        m_we     = 1'b0;
        w_we     = 1'b0;
        ex_ld    = 1'b0;
        m_ld     = 1'b0;
        alu_m    = ALU_D;
        wb_w     = WB_D;
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic to_next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_pipe();
        rst = 1'b1;

        // Reset with a live hazard and an M match: everything must stay on the RF path.
        branch = 1'b1; rs1_addr = 5'd5; m_rd = 5'd5; m_we = 1'b1;
        rs2_addr = 5'd7; ex_rd = 5'd7; ex_we = 1'b1; ex_ld = 1'b1;
        to_next_cycle();
        to_sample();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_valid", 32'(opnd_valid), 32'd0);
        check("rst_sel_a", 32'(sel_a), 32'd0);
        check("rst_a_op", a_op, RS1_D);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        to_next_cycle();
        rst = 1'b0;
        clear_pipe();

        // M and W both write rs1=5: M wins, no stall. rs2=3 has no producer.
        branch = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd3;
        m_rd = 5'd5; m_we = 1'b1; w_rd = 5'd5; w_we = 1'b1;
        to_sample();
        check("mw_sel_a", 32'(sel_a), 32'd1);
        check("mw_a_op", a_op, ALU_D);
        check("mw_sel_b", 32'(sel_b), 32'd0);
        check("mw_b_op", b_op, RS2_D);
        check("mw_stall", 32'(stall), 32'd0);
        check("mw_valid", 32'(opnd_valid), 32'd1);
        to_next_cycle();
        clear_pipe();

        // W-only match on rs2.
        branch = 1'b1; rs2_addr = 5'd9; w_rd = 5'd9; w_we = 1'b1;
        to_sample();
        check("w_sel_b", 32'(sel_b), 32'd2);
        check("w_b_op", b_op, WB_D);
        to_next_cycle();
        clear_pipe();

        // x0 never forwards and never stalls, even against a load in EX writing x0.
        branch = 1'b1; rs1_addr = 5'd0; m_rd = 5'd0; m_we = 1'b1;
        ex_rd = 5'd0; ex_we = 1'b1; ex_ld = 1'b1;
        to_sample();
        check("x0_sel_a", 32'(sel_a), 32'd0);
        check("x0_a_op", a_op, RS1_D);
        check("x0_stall", 32'(stall), 32'd0);
        to_next_cycle();
        clear_pipe();

        // Load in EX writing rs2=7: two stall cycles, then W forward.
        branch = 1'b1; rs2_addr = 5'd7; ex_rd = 5'd7; ex_we = 1'b1; ex_ld = 1'b1;
        to_sample();
        check("ldex_c1_stall", 32'(stall), 32'd1);
        check("ldex_c1_valid", 32'(opnd_valid), 32'd0);
        to_next_cycle();
        check("ldex_c2_state", 32'(dbg_state), 32'(WAIT));
        ex_rd = '0; ex_we = 1'b0; ex_ld = 1'b0;
        m_rd = 5'd7; m_we = 1'b1; m_ld = 1'b1;
        to_sample();
        check("ldex_c2_stall", 32'(stall), 32'd1);
        to_next_cycle();
        m_rd = '0; m_we = 1'b0; m_ld = 1'b0;
        w_rd = 5'd7; w_we = 1'b1;
        to_sample();
        check("ldex_c3_stall", 32'(stall), 32'd0);
        check("ldex_c3_sel_b", 32'(sel_b), 32'd2);
        check("ldex_c3_b_op", b_op, WB_D);
        check("ldex_c3_valid", 32'(opnd_valid), 32'd1);
        check("ldex_c3_state", 32'(dbg_state), 32'(IDLE));
        to_next_cycle();
        clear_pipe();

        // ALU in EX on rs1 plus load in M on rs2: single stall, then M and W forwards.
        branch = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd6;
        ex_rd = 5'd4; ex_we = 1'b1; m_rd = 5'd6; m_we = 1'b1; m_ld = 1'b1;
        to_sample();
        check("mix_c1_stall", 32'(stall), 32'd1);
        to_next_cycle();
        check("mix_c2_state", 32'(dbg_state), 32'(IDLE));
        ex_rd = '0; ex_we = 1'b0;
        m_rd = 5'd4; m_we = 1'b1; m_ld = 1'b0;
        w_rd = 5'd6; w_we = 1'b1;
        to_sample();
        check("mix_c2_stall", 32'(stall), 32'd0);
        check("mix_c2_sel_a", 32'(sel_a), 32'd1);
        check("mix_c2_sel_b", 32'(sel_b), 32'd2);
        check("mix_c2_valid", 32'(opnd_valid), 32'd1);
        to_next_cycle();
        clear_pipe();

        // Flush during WAIT drops the stall immediately and returns to IDLE.
        branch = 1'b1; rs1_addr = 5'd8; ex_rd = 5'd8; ex_we = 1'b1; ex_ld = 1'b1;
        to_sample();
        check("fl_c1_stall", 32'(stall), 32'd1);
        to_next_cycle();
        ex_rd = '0; ex_we = 1'b0; ex_ld = 1'b0;
        flush = 1'b1;
        to_sample();
        check("fl_c2_stall", 32'(stall), 32'd0);
        check("fl_c2_valid", 32'(opnd_valid), 32'd0);
        to_next_cycle();
        flush = 1'b0;
        to_sample();
        check("fl_c3_state", 32'(dbg_state), 32'(IDLE));
        check("fl_c3_stall", 32'(stall), 32'd0);
        to_next_cycle();
        clear_pipe();

        // Flush on the detecting cycle wins: no stall, no WAIT.
        branch = 1'b1; rs2_addr = 5'd11; ex_rd = 5'd11; ex_we = 1'b1; ex_ld = 1'b1;
        flush = 1'b1;
        to_sample();
        check("fldet_stall", 32'(stall), 32'd0);
        to_next_cycle();
        check("fldet_state", 32'(dbg_state), 32'(IDLE));
        clear_pipe();

        // No branch in ID: hazards are irrelevant.
        rs1_addr = 5'd12; ex_rd = 5'd12; ex_we = 1'b1; ex_ld = 1'b1;
        to_sample();
        check("nobr_stall", 32'(stall), 32'd0);
        check("nobr_valid", 32'(opnd_valid), 32'd0);
        to_next_cycle();
        clear_pipe();

        // Reset during WAIT aborts the stall at the next edge.
        branch = 1'b1; rs1_addr = 5'd13; ex_rd = 5'd13; ex_we = 1'b1; ex_ld = 1'b1;
        to_next_cycle();
        check("rstw_state", 32'(dbg_state), 32'(WAIT));
        ex_rd = '0; ex_we = 1'b0; ex_ld = 1'b0;
        rst = 1'b1;
        to_sample();
        check("rstw_stall", 32'(stall), 32'd0);
        to_next_cycle();
        check("rstw_state_after", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        clear_pipe();

`ifdef BRANCH_FWD_STATS_EN
        // Fresh counters, then a 2-cycle load stall and one forwarded resolve.
        rst = 1'b1;
        to_next_cycle();
        rst = 1'b0;
        branch = 1'b1; rs2_addr = 5'd7; ex_rd = 5'd7; ex_we = 1'b1; ex_ld = 1'b1;
        to_next_cycle();
        ex_rd = '0; ex_we = 1'b0; ex_ld = 1'b0;
        m_rd = 5'd7; m_we = 1'b1; m_ld = 1'b1;
        to_next_cycle();
        m_rd = '0; m_we = 1'b0; m_ld = 1'b0;
        w_rd = 5'd7; w_we = 1'b1;
        to_next_cycle();
        clear_pipe();
        to_sample();
        check("st_stall_cyc", stall_cyc, 32'd2);
        check("st_fwd_evt", fwd_evt, 32'd1);
        rst = 1'b1;
        to_next_cycle();
        rst = 1'b0;
        to_sample();
        check("st_clr_stall_cyc", stall_cyc, 32'd0);
        check("st_clr_fwd_evt", fwd_evt, 32'd0);
`endif

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_fwd_unit.md
# branch_fwd_unit

- Branch-operand forwarding and hazard unit for the ID stage of the 5-stage RISC-V pipeline; generalised successor of the fixed-code branch operand mux.
- Derives forwarding selects itself from register addresses and pipeline-stage tags, so no pre-encoded select code is needed.
- Delivers the two branch comparison operands and drives a cycle-counted stall when a producer's value is not yet available.
- Sits between the register file read port and the branch comparator / PC-select logic.

## Interface
Parameters:
- XLEN, 32, data width of operands and forwarded values
- RA_W, 5, register address width

Ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- branch_i  in  1  ID holds a branch/JALR that needs operands
- flush_i  in  1  ID instruction killed (redirect)
- rs1_addr_i, rs2_addr_i  in  RA_W  ID source registers
- rs1_data_i, rs2_data_i  in  XLEN  register file read data
- ex_rd_i, m_rd_i, w_rd_i  in  RA_W  destination register of EX / M / W
- ex_we_i, m_we_i, w_we_i  in  1  stage writes rd
- ex_ld_i, m_ld_i  in  1  stage instruction is a load
- alu_m_i  in  XLEN  ALU result in M
- wb_w_i  in  XLEN  writeback value in W
- a_operand_o, b_operand_o  out  XLEN  forwarded branch operands
- sel_a_o, sel_b_o  out  2  forwarding select applied (0 RF, 1 M, 2 W)
- stall_o  out  1  freeze PC/IF/ID, bubble into EX
- opnd_valid_o  out  1  operands final this cycle (`branch_i & ~stall_o & ~flush_i`)

## Operation
Forwarding, per operand:
- Source x0 is never forwarded (select 0).
- M match (`m_we_i`, `~m_ld_i`, `m_rd_i == rs`) → select 1, alu_m_i.
- Otherwise W match (`w_we_i`, `w_rd_i == rs`) → select 2, wb_w_i.
- Otherwise select 0, RF data. M has priority over W.

Hazard cost N per operand, only when `branch_i`:
- EX match with `ex_ld_i` → 2.
- EX match, non-load → 1.
- M match with `m_ld_i` → 1.
- Otherwise 0.
- Stall length is N = max(N_a, N_b).

FSM (IDLE, WAIT) with 2-bit counter cnt:
- IDLE, N > 0: stall_o = 1 combinationally this cycle. If N == 2, load cnt = 1 and go to WAIT; if N == 1, stay in IDLE.
- IDLE, N == 0: stall_o = 0.
- WAIT: stall_o = 1 unconditionally and hazards are ignored. cnt decrements; go to IDLE when cnt reaches 0, and re-evaluate hazards there.
- flush_i in any state: forces IDLE, cnt = 0, stall_o = 0, opnd_valid_o = 0. Flush wins over a same-cycle detection.
- Operands and selects are always computed combinationally from current inputs, including during a stall.

## Timing
- Reset (rst_i high at an edge): state IDLE, cnt 0.
- While rst_i is high: stall_o = 0, opnd_valid_o = 0, sel_*_o = 0, operands = RF data.
- Stall cycles (the branch resolves on the first cycle after the last stall):
  - ALU producer in EX: 1 stall, then M forward.
  - Load in EX: 2 stalls, then W forward.
  - Load in M: 1 stall, then W forward.
- No added latency on the operand path (zero registers in the data path).
- Reset asserted during WAIT aborts the stall at the next edge.

## Configuration
- `BRANCH_FWD_STATS_EN` defined: adds outputs stall_cyc_o[31:0] and fwd_evt_o[31:0].
  - stall_cyc_o counts cycles with stall_o = 1.
  - fwd_evt_o counts cycles with opnd_valid_o = 1 and any select ≠ 0.
  - Both saturate at all-ones and clear on rst_i.
- `BRANCH_FWD_STATS_EN` undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Package branch_fwd_pkg holds:
  - fwd_sel_e (FWD_RF = 0, FWD_M = 1, FWD_W = 2)
  - state_e (IDLE, WAIT)
  - localparam MAX_STALL = 2
- Sub-module branch_fwd_sel: per-operand combinational match, select and cost logic, instantiated twice (operand a, operand b).
- The FSM, counter and stats counters live in the top module.

## Test plan
- rs1 = 5 matches m_rd_i = 5 (ALU), and w_rd_i = 5 also writes → a_operand_o = alu_m_i, sel_a_o = 1 (M wins), stall_o = 0.
- rs1 = 0 with m_rd_i = 0, m_we_i = 1 → sel_a_o = 0, a_operand_o = rs1_data_i.
- Load in EX with ex_rd_i = rs2 = 7 → stall_o high for exactly 2 cycles. On the 3rd cycle: sel_b_o = 2, b_operand_o = wb_w_i, opnd_valid_o = 1.
- rs1 matches ALU in EX, and rs2 matches load in M → single 1-cycle stall. Next cycle: sel_a_o = 1, sel_b_o = 2.
- Load-in-EX hazard, flush_i pulsed in the second (WAIT) cycle → stall_o = 0 in that cycle, state IDLE afterwards.
- With `BRANCH_FWD_STATS_EN`: after the 2-cycle load stall plus one forwarded resolve → stall_cyc_o = 2, fwd_evt_o = 1; rst_i clears both to 0.
